// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs and operand outputs
// of the ALU operand loader.
interface alu_operand_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_a;
  logic [NB_DATA-1:0] o_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_valid;
  logic [1:0]         o_state;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_a, o_b, o_op, o_valid, o_state
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_a, o_b, o_op, o_valid, o_state
  );
endinterface

// File: rtl/alu_operand_loader.sv
// ALU front end: debounced buttons load A, B
// and opcode from the switches in fixed order.
module alu_operand_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_loader_if.slave bus
);

  localparam logic [15:0] CNT_MAX =
    16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2
  } state_t;

  // bit 0 = A, bit 1 = B, bit 2 = OP
  logic [2:0]       btn;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       deb_prev_q;
  logic [2:0][15:0] cnt_q, cnt_d;
  logic [2:0]       press;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               valid_q, valid_d;

  assign btn = {bus.i_btn_op, bus.i_btn_b,
                bus.i_btn_a};

  // Count cycles the synced level differs from
  // the debounced one; any return resets it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Synchronizers, debounce state, edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Only the press expected in the current
  // state acts; all others are dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = 1'b0;
    unique case (state_q)
      WAIT_A: begin
        if (press[0]) begin
          a_d     = bus.i_sw;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press[1]) begin
          b_d     = bus.i_sw;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (press[2]) begin
          op_d    = bus.i_sw[NB_OP-1:0];
          valid_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  // Operand, opcode and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_a     = a_q;
  assign bus.o_b     = b_q;
  assign bus.o_op    = op_q;
  assign bus.o_valid = valid_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader,
// DEBOUNCE_CYCLES = 4 (load after 7 edges).
module tb_alu_operand_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_operand_loader_if #(
    .NB_DATA(8), .NB_OP(6)
  ) bus ();

  alu_operand_loader #(
    .NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         msk;
    logic [7:0] sw;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [5:0] eop;
    int         est;
    int         elat;
    int         evld;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic set_btn(input int msk,
                         input logic v);
    if (msk[0]) bus.i_btn_a  = v;
    if (msk[1]) bus.i_btn_b  = v;
    if (msk[2]) bus.i_btn_op = v;
  endtask

  // Watch n edges: first edge (1-based) at
  // which o_state moves, valid at that edge,
  // and total cycles with o_valid high.
  task automatic watch(input int n,
                       output int lat,
                       output int vat,
                       output int vcnt);
    logic [1:0] st0;
    st0  = bus.o_state;
    lat  = -1;
    vat  = 0;
    vcnt = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && bus.o_state != st0) begin
        lat = i;
        vat = int'(bus.o_valid);
      end
      if (bus.o_valid) vcnt++;
    end
  endtask

  task automatic do_press(input int msk,
                          input logic [7:0] sw,
                          input int hold,
                          output int lat,
                          output int vat,
                          output int vcnt);
    int l2, v2, c2;
    @(negedge clk);
    bus.i_sw = sw;
    set_btn(msk, 1'b1);
    watch(hold, lat, vat, vcnt);
    @(negedge clk);
    set_btn(msk, 1'b0);
    watch(12, l2, v2, c2);
    vcnt += c2;
    if (lat < 0) lat = (l2 < 0) ? -1 : 100;
  endtask

  task automatic chk_regs(input string nm,
                          input logic [7:0] ea,
                          input logic [7:0] eb,
                          input logic [5:0] eop,
                          input int est);
    chk({nm, " a"},  int'(bus.o_a),  int'(ea));
    chk({nm, " b"},  int'(bus.o_b),  int'(eb));
    chk({nm, " op"}, int'(bus.o_op), int'(eop));
    chk({nm, " st"}, int'(bus.o_state), est);
  endtask

  initial begin
    int lat, vat, vcnt;
    vecs[0] = '{1, 8'h3C, 8'h3C, 8'h00, 6'h00, 1,  7, 0};
    vecs[1] = '{2, 8'h05, 8'h3C, 8'h05, 6'h00, 2,  7, 0};
    vecs[2] = '{4, 8'hE7, 8'h3C, 8'h05, 6'h27, 0,  7, 1};
    vecs[3] = '{2, 8'hAA, 8'h3C, 8'h05, 6'h27, 0, -1, 0};
    vecs[4] = '{4, 8'hFF, 8'h3C, 8'h05, 6'h27, 0, -1, 0};
    vecs[5] = '{1, 8'h11, 8'h11, 8'h05, 6'h27, 1,  7, 0};
    vecs[6] = '{4, 8'h22, 8'h11, 8'h05, 6'h27, 1, -1, 0};
    vecs[7] = '{2, 8'h80, 8'h11, 8'h80, 6'h27, 2,  7, 0};
    vecs[8] = '{1, 8'h99, 8'h11, 8'h80, 6'h27, 2, -1, 0};
    vecs[9] = '{4, 8'hC9, 8'h11, 8'h80, 6'h09, 0,  7, 1};

    rst_n        = 1'b0;
    bus.i_sw     = '0;
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    #3;
    chk_regs("reset0", 8'h00, 8'h00, 6'h00, 0);
    chk("reset0 valid", int'(bus.o_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_press(vecs[i].msk, vecs[i].sw, 10,
               lat, vat, vcnt);
      chk_regs(nm, vecs[i].ea, vecs[i].eb,
               vecs[i].eop, vecs[i].est);
      chk({nm, " lat"}, lat, vecs[i].elat);
      chk({nm, " vcnt"}, vcnt, vecs[i].evld);
      if (vecs[i].elat > 0)
        chk({nm, " vat"}, vat, vecs[i].evld);
    end

    // Bounce 1,0,1,0 then held high.
    @(negedge clk);
    bus.i_sw = 8'h44;
    bus.i_btn_a = 1'b1;
    @(negedge clk) bus.i_btn_a = 1'b0;
    @(negedge clk) bus.i_btn_a = 1'b1;
    @(negedge clk) bus.i_btn_a = 1'b0;
    @(negedge clk) bus.i_btn_a = 1'b1;
    watch(12, lat, vat, vcnt);
    chk("bounce lat", lat, 7);
    @(negedge clk) bus.i_btn_a = 1'b0;
    watch(12, lat, vat, vcnt);
    chk_regs("bounce", 8'h44, 8'h80, 6'h09, 1);

    // 3-cycle B pulse is rejected.
    @(negedge clk);
    bus.i_sw = 8'hBB;
    bus.i_btn_b = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_btn_b = 1'b0;
    watch(15, lat, vat, vcnt);
    chk("glitch lat", lat, -1);
    chk_regs("glitch", 8'h44, 8'h80, 6'h09, 1);

    // A and B together in WAIT_B.
    do_press(3, 8'h5A, 10, lat, vat, vcnt);
    chk("simul lat", lat, 7);
    chk_regs("simul", 8'h44, 8'h5A, 6'h09, 2);

    // OP held 70 cycles: one pulse only.
    do_press(4, 8'h0F, 70, lat, vat, vcnt);
    chk("hold lat", lat, 7);
    chk("hold vat", vat, 1);
    chk("hold vcnt", vcnt, 1);
    chk_regs("hold", 8'h44, 8'h5A, 6'h0F, 0);

    // Async reset from WAIT_OP, off-edge.
    do_press(1, 8'h12, 10, lat, vat, vcnt);
    do_press(2, 8'h34, 10, lat, vat, vcnt);
    chk_regs("prerst", 8'h12, 8'h34, 6'h0F, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs("asyncrst", 8'h00, 8'h00, 6'h00, 0);
    chk("asyncrst valid", int'(bus.o_valid), 0);

    // A held through reset release.
    bus.i_sw = 8'h77;
    bus.i_btn_a = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    watch(20, lat, vat, vcnt);
    chk("rstheld lat", lat, 7);
    chk_regs("rstheld", 8'h77, 8'h00, 6'h00, 1);
    watch(30, lat, vat, vcnt);
    chk("rstheld again", lat, -1);
    @(negedge clk) bus.i_btn_a = 1'b0;
    watch(10, lat, vat, vcnt);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
